// File: rtl/pending_encoder_rr.sv
// Pending-request encoder: latches request pulses and hands out one pending
// index per valid/ready transfer. Selection is fixed (highest index) or round-robin.
module pending_encoder_rr #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_in,
  input  logic             mode,
  input  logic             ready_in,
  output logic             valid_out,
  output logic [IDX_W-1:0] idx_out,
  output logic [N-1:0]     pending_out
);

  logic [N-1:0]     pend_q, pend_d;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  logic             acc;
  logic             load;
  logic [N-1:0]     clr;
  logic [N-1:0]     sel;
  logic [IDX_W-1:0] pick_fixed;
  logic [IDX_W-1:0] pick_rr;

  assign acc  = valid_q & ready_in;
  assign load = ~valid_q | ready_in;

  for (genvar gi = 0; gi < N; gi++) begin : g_clr
    assign clr[gi] = acc && (idx_q == IDX_W'(gi));
  end

  // Selection sees the current pending set minus the bit leaving this cycle;
  // fresh requests only become eligible one cycle later.
  assign sel = pend_q & ~clr;

  always_comb begin
    pick_fixed = '0;
    for (int i = 0; i < N; i++) begin
      if (sel[i]) pick_fixed = IDX_W'(i);
    end
  end

  // Round-robin: lowest set index above ptr, otherwise wrap to lowest set index.
  always_comb begin
    logic [IDX_W-1:0] hi_idx;
    logic [IDX_W-1:0] lo_idx;
    logic             hi_found;
    hi_idx   = '0;
    lo_idx   = '0;
    hi_found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (sel[i]) begin
        lo_idx = IDX_W'(i);
        if (i > int'(ptr_q)) begin
          hi_idx   = IDX_W'(i);
          hi_found = 1'b1;
        end
      end
    end
    pick_rr = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    pend_d  = sel | req_in;
    ptr_d   = acc ? idx_q : ptr_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    if (load) begin
      valid_d = |sel;
      idx_d   = (|sel) ? (mode ? pick_rr : pick_fixed) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q  <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      ptr_q   <= IDX_W'(N - 1);
    end else begin
      pend_q  <= pend_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

  assign valid_out   = valid_q;
  assign idx_out     = idx_q;
  assign pending_out = pend_q;

endmodule
